// File: rtl/letter_fetcher_pkg.sv
// Shared parameters and types for the address splitter / letter fetcher pair.
// Also holds the letter extraction helper used on returning memory words.
package letter_fetcher_pkg;

  localparam int unsigned WORDINDEXBITS   = 4;
  localparam int unsigned LETTERINDEXBITS = 2;
  localparam int unsigned LETTERBITS      = 8;
  localparam int unsigned MEMLATENCY      = 2;
  localparam int unsigned FIFODEPTH       = 4;

  localparam int unsigned WORDBITS       = LETTERBITS << LETTERINDEXBITS;
  localparam int unsigned LETTERSPERWORD = 1 << LETTERINDEXBITS;
  localparam int unsigned INFLIGHTBITS   = $clog2(FIFODEPTH + 1);

  typedef logic [WORDINDEXBITS-1:0]   word_idx_t;
  typedef logic [LETTERINDEXBITS-1:0] letter_idx_t;
  typedef logic [LETTERBITS-1:0]      letter_t;
  typedef logic [WORDBITS-1:0]        word_t;
  typedef logic [INFLIGHTBITS-1:0]    inflight_t;

  // Letter 0 lives in the least significant bits of the word.
  function automatic letter_t extract_letter(input word_t word, input letter_idx_t idx);
    letter_t l;
    l = '0;
    for (int k = 0; k < int'(LETTERSPERWORD); k++) begin
      if (idx == letter_idx_t'(k)) l = word[k*LETTERBITS +: LETTERBITS];
    end
    return l;
  endfunction

endpackage

// File: rtl/letter_fetcher_if.sv
// Request, memory-read and letter-output signals of the letter fetcher.
// slave is the fetcher's view; master is the view of its environment.
interface letter_fetcher_if;
  import letter_fetcher_pkg::*;

  logic        in_valid;
  logic        in_ready;
  word_idx_t   wordIndex;
  letter_idx_t letterIndex;
  logic        mem_rd_en;
  word_idx_t   mem_rd_addr;
  word_t       mem_rd_data;
  logic        out_valid;
  logic        out_ready;
  letter_t     letter;

  modport slave (
    input  in_valid, wordIndex, letterIndex, mem_rd_data, out_ready,
    output in_ready, mem_rd_en, mem_rd_addr, out_valid, letter
  );

  modport master (
    output in_valid, wordIndex, letterIndex, mem_rd_data, out_ready,
    input  in_ready, mem_rd_en, mem_rd_addr, out_valid, letter
  );

endinterface

// File: rtl/letter_fetcher_sync_fifo.sv
// sync_fifo: first-word-fall-through FIFO with synchronous active-low reset.
// Depth must be a power of two so the pointers wrap on their own.
module letter_fetcher_sync_fifo #(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       wr_en_i,
  input  logic [Width-1:0]           wr_data_i,
  input  logic                       rd_en_i,
  output logic [Width-1:0]           rd_data_o,
  output logic                       empty_o,
  output logic                       full_o,
  output logic [$clog2(Depth+1)-1:0] count_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = $clog2(Depth + 1);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             do_wr, do_rd;

  assign empty_o   = (count_q == '0);
  assign full_o    = (count_q == CntW'(Depth));
  assign count_o   = count_q;
  assign rd_data_o = mem_q[rd_ptr_q];

  assign do_wr = wr_en_i && !full_o;
  assign do_rd = rd_en_i && !empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_wr) wr_ptr_d = wr_ptr_q + PtrW'(1);
    if (do_rd) rd_ptr_d = rd_ptr_q + PtrW'(1);
    if (do_wr && !do_rd) begin
      count_d = count_q + CntW'(1);
    end else if (!do_wr && do_rd) begin
      count_d = count_q - CntW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < int'(Depth); i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (do_wr) mem_q[wr_ptr_q] <= wr_data_i;
    end
  end

endmodule

// File: rtl/letter_fetcher.sv
// Issues word reads for (wordIndex, letterIndex) requests and returns the addressed
// letters in order; credits reserve a FIFO slot per read since memory cannot stall.
module letter_fetcher
  import letter_fetcher_pkg::*;
(
  input logic             clock,
  input logic             reset_n,
  letter_fetcher_if.slave lf
);

  localparam inflight_t DepthCredits = inflight_t'(FIFODEPTH);

  logic                             accept, pop;
  word_idx_t                        addr_q;
  inflight_t                        inflight_q, inflight_d;
  logic        [MEMLATENCY-1:0]     tag_vld_q, tag_vld_d;
  letter_idx_t [MEMLATENCY-1:0]     tag_idx_q, tag_idx_d;
  logic                             fifo_wr, fifo_empty, fifo_full;
  letter_t                          fifo_wr_data;
  logic        [INFLIGHTBITS-1:0]   fifo_count;

  assign lf.in_ready    = reset_n && (inflight_q < DepthCredits);
  assign accept         = lf.in_valid && lf.in_ready;
  assign lf.mem_rd_en   = accept;
  assign lf.mem_rd_addr = accept ? lf.wordIndex : addr_q;
  assign lf.out_valid   = !fifo_empty;
  assign pop            = lf.out_valid && lf.out_ready;

  // The last tag stage is aligned with the word coming back from memory.
  assign fifo_wr      = tag_vld_q[MEMLATENCY-1];
  assign fifo_wr_data = extract_letter(lf.mem_rd_data, tag_idx_q[MEMLATENCY-1]);

  always_comb begin
    tag_vld_d    = tag_vld_q;
    tag_idx_d    = tag_idx_q;
    tag_vld_d[0] = accept;
    tag_idx_d[0] = lf.letterIndex;
    for (int k = 1; k < int'(MEMLATENCY); k++) begin
      tag_vld_d[k] = tag_vld_q[k-1];
      tag_idx_d[k] = tag_idx_q[k-1];
    end
  end

  always_comb begin
    inflight_d = inflight_q;
    case ({accept, pop})
      2'b10:   inflight_d = inflight_q + inflight_t'(1);
      2'b01:   inflight_d = inflight_q - inflight_t'(1);
      default: inflight_d = inflight_q;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      addr_q     <= '0;
      inflight_q <= '0;
      tag_vld_q  <= '0;
      tag_idx_q  <= '0;
    end else begin
      if (accept) addr_q <= lf.wordIndex;
      inflight_q <= inflight_d;
      tag_vld_q  <= tag_vld_d;
      tag_idx_q  <= tag_idx_d;
    end
  end

  letter_fetcher_sync_fifo #(
    .Width (LETTERBITS),
    .Depth (FIFODEPTH)
  ) u_fifo (
    .clk_i     (clock),
    .rst_ni    (reset_n),
    .wr_en_i   (fifo_wr),
    .wr_data_i (fifo_wr_data),
    .rd_en_i   (pop),
    .rd_data_o (lf.letter),
    .empty_o   (fifo_empty),
    .full_o    (fifo_full),
    .count_o   (fifo_count)
  );

`ifndef SYNTHESIS
  a_no_fifo_overflow: assert property (@(posedge clock) disable iff (!reset_n)
    !(fifo_wr && fifo_full));
  a_inflight_bound: assert property (@(posedge clock) disable iff (!reset_n)
    inflight_q <= DepthCredits);
  a_credit_balance: assert property (@(posedge clock) disable iff (!reset_n)
    int'(inflight_q) == $countones(tag_vld_q) + int'(fifo_count));
  a_rd_data_known: assert property (@(posedge clock) disable iff (!reset_n)
    fifo_wr |-> !$isunknown(lf.mem_rd_data));
`endif

endmodule

// File: tb/tb_letter_fetcher.sv
// Bench for letter_fetcher: word memory model, queue-based reference model checked
// every cycle, plus directed scenarios with literal expectations.
module tb_letter_fetcher;
  import letter_fetcher_pkg::*;

  logic clock;
  logic reset_n;
  int   cyc;
  int   n_checks;
  int   n_fail;

  letter_fetcher_if lf ();

  letter_fetcher u_dut (
    .clock   (clock),
    .reset_n (reset_n),
    .lf      (lf)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // Memory: word k holds bytes k*4+3 .. k*4, returned MEMLATENCY cycles after the strobe.
  logic      pipe_v [MEMLATENCY];
  word_idx_t pipe_a [MEMLATENCY];

  function automatic word_t mem_word(input word_idx_t k);
    word_t w;
    for (int l = 0; l < int'(LETTERSPERWORD); l++) w[l*LETTERBITS +: LETTERBITS] = 8'(int'(k) * 4 + l);
    return w;
  endfunction

  initial for (int i = 0; i < int'(MEMLATENCY); i++) begin
    pipe_v[i] = 1'b0;
    pipe_a[i] = '0;
  end

  always @(posedge clock) begin
    pipe_v[0] <= lf.mem_rd_en;
    pipe_a[0] <= lf.mem_rd_addr;
    for (int i = 1; i < int'(MEMLATENCY); i++) begin
      pipe_v[i] <= pipe_v[i-1];
      pipe_a[i] <= pipe_a[i-1];
    end
  end

  assign lf.mem_rd_data = pipe_v[MEMLATENCY-1] ? mem_word(pipe_a[MEMLATENCY-1]) : 32'hDEADBEEF;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: accepted-but-not-delivered letters with the cycle each may first show.
  letter_t   exp_letter [$];
  int        exp_avail  [$];
  word_idx_t last_addr;
  bit        post_rst;
  letter_t   got        [$];
  int        got_cyc    [$];

  always @(negedge clock) begin
    bit exp_valid;
    bit model_acc;
    if (!reset_n) begin
      check("rst_in_ready", 32'(lf.in_ready), 0);
      check("rst_mem_rd_en", 32'(lf.mem_rd_en), 0);
      exp_letter.delete();
      exp_avail.delete();
      last_addr = '0;
      post_rst  = 1'b1;
    end else begin
      model_acc = lf.in_valid && (exp_letter.size() < int'(FIFODEPTH));
      check("in_ready", 32'(lf.in_ready), 32'(exp_letter.size() < int'(FIFODEPTH)));
      check("mem_rd_en", 32'(lf.mem_rd_en), 32'(model_acc));
      if (model_acc) begin
        check("mem_rd_addr", 32'(lf.mem_rd_addr), 32'(lf.wordIndex));
        last_addr = lf.wordIndex;
      end else begin
        check("mem_rd_addr_hold", 32'(lf.mem_rd_addr), 32'(last_addr));
      end
      exp_valid = (exp_letter.size() > 0) && (exp_avail[0] <= cyc);
      check("out_valid", 32'(lf.out_valid), 32'(exp_valid));
      if (post_rst) check("letter_after_reset", 32'(lf.letter), 0);
      if (exp_valid) check("letter", 32'(lf.letter), 32'(exp_letter[0]));
      if (lf.out_valid && lf.out_ready) begin
        got.push_back(lf.letter);
        got_cyc.push_back(cyc);
      end
      if (exp_valid && lf.out_ready) begin
        void'(exp_letter.pop_front());
        void'(exp_avail.pop_front());
      end
      if (model_acc) begin
        exp_letter.push_back(8'(int'(lf.wordIndex) * 4 + int'(lf.letterIndex)));
        exp_avail.push_back(cyc + int'(MEMLATENCY) + 1);
      end
      post_rst = 1'b0;
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic request(input int w, input int l, output int acc_cyc);
    int budget;
    budget = 0;
    lf.in_valid    = 1'b1;
    lf.wordIndex   = WORDINDEXBITS'(w);
    lf.letterIndex = LETTERINDEXBITS'(l);
    #1;
    while (!lf.in_ready && budget < 100) begin
      step();
      budget++;
    end
    check("request_timeout", 32'(lf.in_ready), 1);
    acc_cyc = cyc;
    step();
    lf.in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int budget;
    budget = 0;
    lf.out_ready = 1'b1;
    while (exp_letter.size() != 0 && budget < 200) begin
      step();
      budget++;
    end
    check("drain_timeout", 32'(exp_letter.size()), 0);
    repeat (3) step();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
    $fatal(1);
  end

  initial begin
    int      a0, a1;
    int      n_acc;
    bit      req_done;
    letter_t sent [$];

    n_checks = 0;
    n_fail   = 0;
    reset_n        = 1'b0;
    lf.in_valid    = 1'b0;
    lf.wordIndex   = '0;
    lf.letterIndex = '0;
    lf.out_ready   = 1'b1;
    repeat (3) step();
    reset_n = 1'b1;
    #1;
    check("in_ready_after_release", 32'(lf.in_ready), 1);
    check("out_valid_after_reset", 32'(lf.out_valid), 0);
    step();

    // 1: single request (5,2)
    got.delete(); got_cyc.delete();
    lf.in_valid = 1'b1; lf.wordIndex = 4'd5; lf.letterIndex = 2'd2;
    #1;
    check("t1_rd_en", 32'(lf.mem_rd_en), 1);
    check("t1_rd_addr", 32'(lf.mem_rd_addr), 5);
    a0 = cyc;
    step();
    lf.in_valid = 1'b0;
    wait_drain();
    repeat (4) step();
    check("t1_beats", 32'(got.size()), 1);
    if (got.size() == 1) begin
      check("t1_letter", 32'(got[0]), 32'h16);
      check("t1_latency", 32'(got_cyc[0] - a0), 3);
    end

    // 2: back-to-back requests
    got.delete(); got_cyc.delete();
    request(3, 0, a0);
    request(3, 3, a1);
    request(15, 1, a1);
    wait_drain();
    check("t2_beats", 32'(got.size()), 3);
    if (got.size() == 3) begin
      check("t2_l0", 32'(got[0]), 32'h0C);
      check("t2_l1", 32'(got[1]), 32'h0F);
      check("t2_l2", 32'(got[2]), 32'h3D);
      check("t2_consec1", 32'(got_cyc[1] - got_cyc[0]), 1);
      check("t2_consec2", 32'(got_cyc[2] - got_cyc[1]), 1);
    end

    // 3: backpressure fills exactly FIFODEPTH credits
    got.delete(); got_cyc.delete();
    lf.out_ready = 1'b0;
    lf.in_valid  = 1'b1;
    lf.wordIndex = 4'd7;
    n_acc = 0;
    for (int i = 0; i < 10; i++) begin
      lf.letterIndex = LETTERINDEXBITS'(n_acc);
      #1;
      if (lf.in_ready) n_acc++;
      step();
    end
    lf.in_valid = 1'b0;
    check("t3_accepts", 32'(n_acc), 4);
    check("t3_in_ready_full", 32'(lf.in_ready), 0);
    check("t3_out_valid", 32'(lf.out_valid), 1);
    lf.out_ready = 1'b1;
    step();
    lf.out_ready = 1'b0;
    check("t3_one_pop", 32'(got.size()), 1);
    check("t3_in_ready_again", 32'(lf.in_ready), 1);
    wait_drain();
    check("t3_beats", 32'(got.size()), 4);
    for (int i = 0; i < got.size() && i < 4; i++) check("t3_letter", 32'(got[i]), 32'(8'h1C + i));

    // 4: pop and accept in the same cycle with two entries held
    got.delete(); got_cyc.delete();
    lf.out_ready = 1'b0;
    request(2, 0, a0);
    request(2, 1, a0);
    repeat (5) step();
    lf.out_ready = 1'b1;
    request(9, 3, a0);
    lf.out_ready = 1'b0;
    check("t4_one_pop", 32'(got.size()), 1);
    check("t4_in_ready", 32'(lf.in_ready), 1);
    wait_drain();
    check("t4_beats", 32'(got.size()), 3);
    if (got.size() == 3) begin
      check("t4_l0", 32'(got[0]), 32'h08);
      check("t4_l1", 32'(got[1]), 32'h09);
      check("t4_l2", 32'(got[2]), 32'h27);
    end

    // 5: reset with one FIFO entry and two reads outstanding
    got.delete(); got_cyc.delete();
    lf.out_ready = 1'b0;
    request(4, 0, a0);
    repeat (4) step();
    check("t5_fifo_entry", 32'(lf.out_valid), 1);
    request(5, 1, a0);
    request(6, 2, a0);
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    #1;
    check("t5_in_ready", 32'(lf.in_ready), 1);
    check("t5_out_valid", 32'(lf.out_valid), 0);
    repeat (5) step();
    check("t5_no_stale", 32'(lf.out_valid), 0);
    lf.out_ready = 1'b1;
    request(0, 1, a0);
    wait_drain();
    check("t5_beats", 32'(got.size()), 1);
    if (got.size() == 1) check("t5_letter", 32'(got[0]), 32'h01);

    // 6: random requests with random backpressure
    got.delete(); got_cyc.delete();
    req_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 20; i++) begin
          int w, l;
          w = int'($urandom_range(0, 15));
          l = int'($urandom_range(0, 3));
          sent.push_back(8'(w * 4 + l));
          request(w, l, a0);
          repeat ($urandom_range(0, 2)) step();
        end
        req_done = 1'b1;
      end
      begin
        while (!req_done) begin
          lf.out_ready = 1'($urandom_range(0, 1));
          step();
        end
      end
    join
    wait_drain();
    check("t6_beats", 32'(got.size()), 20);
    for (int i = 0; i < got.size() && i < sent.size(); i++) check("t6_letter", 32'(got[i]), 32'(sent[i]));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
